mux41_rr_arbiter: RTL and testbench
===================================

Name: mux41_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 single-bit mux datapath among four requesters. It samples a 4-bit request vector and issues a one-hot grant. It drives the mux 2-bit select with the granted index and flags when the mux output carries a granted requester's data. Each grant lasts until the requester drops its request or a maximum hold time expires, followed by a programmable idle gap.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one requester may hold the grant (legal range 1..255)
GAP, 1, idle cycles inserted after each release before re-arbitration (legal range 0..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
arb_en  input  1  arbitration enable; low blocks new grants, an in-progress grant still completes
req  input  4  request vector, bit i = requester i
grant  output  4  one-hot grant, all zeros when no owner
sel  output  2  select to the 4:1 mux, index of current or last owner
valid  output  1  high while grant is nonzero (equals |grant)

Behaviour:
- All outputs registered.
- Reset (async, rst_n low): grant=4'b0000, sel=2'b00, valid=0, state=IDLE, hold counter=0, gap counter=0, last-owner pointer=3, so requester 0 has first priority. Reset asserted mid-grant clears grant and valid immediately, without waiting for clk.
- States: IDLE, GRANT, GAP.
- IDLE:
  - At a rising edge with arb_en=1 and req!=0, pick the winner by searching (last+1), (last+2), (last+3), (last+4) mod 4. The first set bit wins.
  - Next state GRANT. grant<=onehot(winner), sel<=winner, valid<=1, hold counter<=1.
  - Latency from sampled req to grant is 1 clock.
  - With arb_en=0 or req==0, stay in IDLE with outputs unchanged (grant=0, sel held).
- GRANT:
  - Each edge, hold counter increments.
  - Release occurs at the edge where req[owner]==0 or hold counter==HOLD_MAX.
  - On release: grant<=0, valid<=0, last<=owner, sel unchanged. Next state is GAP (gap counter<=0) if GAP>0, else IDLE.
  - req changes on non-owner bits are ignored.
  - arb_en has no effect in GRANT.
- GAP:
  - Gap counter increments each edge. At the edge where gap counter==GAP-1, go to IDLE.
  - Grant-low bubble between owners is GAP+1 cycles.
- Fairness:
  - The pointer updates only on release, so a released requester has lowest priority at the next arbitration.
  - A sole requester that times out is re-granted after the bubble.
- Wrap-around: when the pointer is 3, search order is 0,1,2,3.
- Requests are sampled only at the arbitration edge. A pulse that rises and falls between edges is never granted.
- Counter widths: hold counter 8 bits, gap counter 4 bits. Neither wraps in legal operation: the hold counter stops at HOLD_MAX, the gap counter stops at GAP-1.
- Invariants (for assertions):
  - grant is zero or one-hot.
  - valid == |grant.
  - When valid=1, sel == index of the grant bit.

Test Plan:
- Reset then single request: rst_n low then high, req=4'b0100 held → grant=4'b0100, sel=2, valid=1 one edge after req sampled. Releases after exactly 8 grant cycles (HOLD_MAX=8). grant=0 for 2 cycles (GAP=1), then regranted 4'b0100.
- Round-robin rotation: req=4'b1111 constant, HOLD_MAX=2, GAP=0 → grant sequence 0001,0010,0100,1000,0001. Each grant lasts 2 cycles, separated by 1 cycle of grant=0. sel follows 0,1,2,3,0.
- Early release plus wrap-around: owner 3 granted; req[3] drops on cycle 2 while req=4'b0011 pending → grant=0 next edge. After the gap bubble, grant=4'b0001 (pointer 3 wraps to 0), not 0010.
- arb_en gating: arb_en=0, req=4'b0010 for 10 cycles → grant stays 0. arb_en rises → grant=4'b0010 one edge later. Dropping arb_en mid-grant does not shorten that grant.
- Async reset mid-grant: during grant=4'b1000, pull rst_n low between clock edges → grant, valid, sel reach 0 before the next edge. After release, req=4'b1111 → first grant 4'b0001.
- Short request pulse: req[1] pulses high for less than one clock between edges while idle → no grant issued, valid stays 0.

Source files
------------

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 single-bit mux.
// Grants last until the owner drops its request or HOLD_MAX expires, then a GAP-cycle bubble.
module mux41_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned GAP      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       valid
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  localparam logic [7:0] HoldMax = 8'(HOLD_MAX);
  localparam logic [3:0] GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       valid_q, valid_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;

  // Search starts just after the last owner so the released requester goes last.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    cand   = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    last_d  = last_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (arb_en && found) begin
          state_d = StGrant;
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          valid_d = 1'b1;
          hold_d  = 8'd1;
        end
      end
      StGrant: begin
        if (!req[sel_q] || hold_q == HoldMax) begin
          grant_d = 4'b0000;
          valid_d = 1'b0;
          last_d  = sel_q;
          hold_d  = 8'd0;
          if (GAP > 0) begin
            state_d = StGap;
            gap_d   = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= 8'd0;
      gap_q   <= 4'd0;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Bench for mux41_rr_arbiter: table vectors through a scoreboard queue plus hand-written corners.
// Instance a uses defaults (HOLD_MAX=8, GAP=1); instance b uses HOLD_MAX=2, GAP=0.
module tb_mux41_rr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic [3:0] req_a = 4'b0, req_b = 4'b0;
  logic [3:0] grant_a, grant_b;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b;

  int checks = 0;
  int errors = 0;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  mux41_rr_arbiter dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_en(en_a),
    .req   (req_a),
    .grant (grant_a),
    .sel   (sel_a),
    .valid (valid_a)
  );

  mux41_rr_arbiter #(.HOLD_MAX(2), .GAP(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_en(en_b),
    .req   (req_b),
    .grant (grant_b),
    .sel   (sel_b),
    .valid (valid_b)
  );

  task automatic cmp(input string name, input logic [3:0] ag, input logic [1:0] as,
                     input logic av, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev);
    checks++;
    if (ag !== eg || as !== es || av !== ev) begin
      errors++;
      $display("FAIL %s: got grant=%b sel=%0d valid=%b, expected grant=%b sel=%0d valid=%b",
               name, ag, as, av, eg, es, ev);
    end
  endtask

  // Structural invariants on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!(grant_a == 4'b0 || $onehot(grant_a)) || valid_a !== (|grant_a) ||
          (valid_a && grant_a != (4'b0001 << sel_a))) begin
        errors++;
        $display("FAIL invariant_a: got grant=%b sel=%0d valid=%b", grant_a, sel_a, valid_a);
      end
      checks++;
      if (!(grant_b == 4'b0 || $onehot(grant_b)) || valid_b !== (|grant_b) ||
          (valid_b && grant_b != (4'b0001 << sel_b))) begin
        errors++;
        $display("FAIL invariant_b: got grant=%b sel=%0d valid=%b", grant_b, sel_b, valid_b);
      end
    end
  end

  task automatic add(input logic [3:0] r, input logic e, input logic [3:0] g,
                     input logic [1:0] s, input logic v);
    vec_t x;
    x.req = r; x.en = e; x.g = g; x.s = s; x.v = v;
    tbl.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 4'b0; req_b = 4'b0; en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive each vector at a negedge, expect its outputs after the following posedge.
  task automatic run_table(input int d, input string tag);
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      if (d == 0) begin
        req_a = tbl[i].req; en_a = tbl[i].en;
      end else begin
        req_b = tbl[i].req; en_b = tbl[i].en;
      end
      e.idx = i; e.g = tbl[i].g; e.s = tbl[i].s; e.v = tbl[i].v;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      if (d == 0)
        cmp($sformatf("%s[%0d]", tag, e.idx), grant_a, sel_a, valid_a, e.g, e.s, e.v);
      else
        cmp($sformatf("%s[%0d]", tag, e.idx), grant_b, sel_b, valid_b, e.g, e.s, e.v);
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    cmp("reset_a", grant_a, sel_a, valid_a, 4'b0, 2'd0, 1'b0);
    cmp("reset_b", grant_b, sel_b, valid_b, 4'b0, 2'd0, 1'b0);

    // Single request: 8-cycle hold, 2-cycle bubble, regrant.
    for (int i = 0; i < 8; i++) add(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);
    add(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);
    add(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
    run_table(0, "single");

    // Rotation on the HOLD_MAX=2, GAP=0 instance.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add(4'b1111, 1'b1, 4'b0001 << i, 2'(i), 1'b1);
      add(4'b1111, 1'b1, 4'b0001 << i, 2'(i), 1'b1);
      add(4'b1111, 1'b1, 4'b0000, 2'(i), 1'b0);
    end
    add(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    run_table(1, "rotate");

    // Early release by owner 3, then pointer wraps to requester 0.
    do_reset();
    add(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1);
    add(4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1);
    add(4'b0011, 1'b1, 4'b0000, 2'd3, 1'b0);
    add(4'b0011, 1'b1, 4'b0000, 2'd3, 1'b0);
    add(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);
    run_table(0, "wrap");

    // arb_en gating; dropping it mid-grant keeps the full hold.
    do_reset();
    for (int i = 0; i < 10; i++) add(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 7; i++) add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0);
    run_table(0, "arb_en");

    // Asynchronous reset between edges while owner 3 holds the grant.
    do_reset();
    req_a = 4'b1000; en_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp("pre_async", grant_a, sel_a, valid_a, 4'b1000, 2'd3, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset", grant_a, sel_a, valid_a, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    cmp("after_async", grant_a, sel_a, valid_a, 4'b0001, 2'd0, 1'b1);

    // Sub-cycle pulse on req[1] between edges must never be granted.
    do_reset();
    en_a = 1'b1;
    @(posedge clk);
    #2 req_a = 4'b0010;
    #2 req_a = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp($sformatf("pulse[%0d]", i), grant_a, sel_a, valid_a, 4'b0000, 2'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
